// File: rtl/bus_master_seq.sv
// Single-master sequencer for the shared tri-state bus `ad`: turns valid/ready requests
// into write strobes, read enables and float turnarounds. Optional macro: BUS_MASTER_SEQ_FLOATCHK_EN.
module bus_master_seq #(
  parameter int WIDTH       = 32,
  parameter int TURN_CYCLES = 1,
  parameter int READ_WAIT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  inout  wire  [WIDTH-1:0] ad,
  output logic             read,
  output logic             write,
  output logic             bus_err
);

  localparam int MAXC = (TURN_CYCLES > READ_WAIT) ? TURN_CYCLES : READ_WAIT;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, TURN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             ad_en_q, ad_en_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  assign req_ready = (state_q == IDLE) && !reset;
  assign read      = read_q;
  assign write     = write_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // Master drive path; only enabled for the single WR cycle.
  for (genvar i = 0; i < WIDTH; i++) begin : g_drv
    bufif1 u_drv (ad[i], wdata_q[i], ad_en_q);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    ad_en_d     = 1'b0;
    read_d      = 1'b1;
    write_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_write) begin
            wdata_d = req_wdata;
            ad_en_d = 1'b1;
            write_d = 1'b1;
            state_d = WR;
          end else begin
            read_d  = 1'b0;
            cnt_d   = CW'(READ_WAIT - 1);
            state_d = RD;
          end
        end
      end
      WR: begin
        cnt_d   = CW'(TURN_CYCLES - 1);
        state_d = TURN;
      end
      RD: begin
        if (cnt_q == '0) begin
          // Sample while the slave is still enabled; read rises at this same edge.
          rsp_rdata_d = ad;
          rsp_valid_d = 1'b1;
          cnt_d       = CW'(TURN_CYCLES - 1);
          state_d     = TURN;
        end else begin
          read_d = 1'b0;
          cnt_d  = cnt_q - CW'(1);
        end
      end
      TURN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wdata_q     <= '0;
      ad_en_q     <= 1'b0;
      read_q      <= 1'b1;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      ad_en_q     <= ad_en_d;
      read_q      <= read_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef BUS_MASTER_SEQ_FLOATCHK_EN
  // Anything other than a fully floating bus at the end of turnaround is a rogue driver.
  logic bus_err_q;
  logic float_bad;
  assign float_bad = (state_q == TURN) && (cnt_q == '0) && (ad !== {WIDTH{1'bz}});
  always_ff @(posedge clk) begin
    if (reset)          bus_err_q <= 1'b0;
    else if (float_bad) bus_err_q <= 1'b1;
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_seq.sv
// Bench for bus_master_seq with a 16-bit register slave on the bus; a cycle-indexed
// reference model predicts every strobe, response and ready window from accept times.
module tb_bus_master_seq;
  localparam int W  = 32;
  localparam int TC = 2;
  localparam int RW = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [W-1:0] req_wdata = '0;
  logic         req_ready, rsp_valid, read, write, bus_err;
  logic [W-1:0] rsp_rdata;
  wire  [W-1:0] ad;

  logic         rogue = 1'b0;
  logic [15:0]  slv_q = '0;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;

  bus_master_seq #(.WIDTH(W), .TURN_CYCLES(TC), .READ_WAIT(RW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ad(ad), .read(read), .write(write), .bus_err(bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-bit register slave, plus a rogue driver on bit 0 used only for the float check.
  always @(posedge clk) if (write) slv_q <= ad[15:0];
  assign ad[15:1] = !read ? slv_q[15:1] : 15'bz;
  assign ad[0]    = !read ? slv_q[0] : (rogue ? 1'b1 : 1'bz);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state, all expressed as absolute cycle numbers.
  int          ready_from = 0;
  int          exp_wr_cyc = -1, exp_rsp_cyc = -1;
  int          turn_lo = -1, turn_hi = -2, rd_lo = -1, rd_hi = -2;
  int          last_acc = -1, exp_gap = 0;
  logic [W-1:0] exp_wdata = '0;
  logic [15:0] ref_reg = '0, exp_rdata = '0;
  logic        exp_err = 1'b0;
  bit          b2b = 1'b0, prev_b2b = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      ready_from = 0; exp_wr_cyc = -1; exp_rsp_cyc = -1;
      turn_lo = -1; turn_hi = -2; rd_lo = -1; rd_hi = -2;
      exp_err = 1'b0; prev_b2b = 1'b0;
    end else begin
      chk("req_ready", req_ready, cyc >= ready_from);
      chk("write_strobe", write, cyc == exp_wr_cyc);
      if (cyc == exp_wr_cyc) chk("wr_ad", ad, exp_wdata);
      chk("rsp_valid", rsp_valid, cyc == exp_rsp_cyc);
      if (cyc == exp_rsp_cyc) chk("rsp_rdata", rsp_rdata[15:0], exp_rdata);
      if (cyc >= rd_lo && cyc <= rd_hi) chk("rd_low", {dut.ad_en_q, read, write}, 3'b000);
      if (cyc >= turn_lo && cyc <= turn_hi) chk("turn_float", {dut.ad_en_q, read, write}, 3'b010);
      chk("no_contention", dut.ad_en_q && !read, 1'b0);
      chk("wr_rd_excl", write && !read, 1'b0);
      chk("bus_err", bus_err, exp_err);
`ifdef BUS_MASTER_SEQ_FLOATCHK_EN
      if (cyc == turn_hi && rogue) exp_err = 1'b1;
`endif
      if (req_valid && req_ready) begin
        if (b2b && prev_b2b) chk("accept_spacing", cyc - last_acc, exp_gap);
        prev_b2b = b2b;
        last_acc = cyc;
        if (req_write) begin
          exp_wr_cyc = cyc + 1;
          exp_wdata  = req_wdata;
          ref_reg    = req_wdata[15:0];
          turn_lo    = cyc + 2;
          turn_hi    = cyc + 1 + TC;
          ready_from = cyc + 2 + TC;
          exp_gap    = 2 + TC;
        end else begin
          rd_lo       = cyc + 1;
          rd_hi       = cyc + RW;
          exp_rsp_cyc = cyc + RW + 1;
          exp_rdata   = ref_reg;
          turn_lo     = cyc + RW + 1;
          turn_hi     = cyc + RW + TC;
          ready_from  = cyc + RW + TC + 1;
          exp_gap     = 1 + RW + TC;
        end
      end
    end
  end

  // Presents a request from just after a posedge and returns just after its accept edge.
  task automatic send(input logic w, input logic [W-1:0] d);
    bit ok = 1'b0;
    int n = 0;
    req_valid = 1'b1; req_write = w; req_wdata = d;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      n++;
    end
    chk("accept_in_time", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic err_exp;
`ifdef BUS_MASTER_SEQ_FLOATCHK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read", read, 1'b1);
    chk("rst_write", write, 1'b0);
    chk("rst_ad_en", dut.ad_en_q, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Write then read through the 16-bit slave.
    send(1'b1, 32'haaaa_aaaa); req_valid = 1'b0;
    send(1'b0, '0);            req_valid = 1'b0;
    idle(RW + TC + 1);
    chk("wr_rd_rdata", rsp_rdata[15:0], 16'haaaa);

    // Rogue driver on ad[0] across the turnaround after a write.
    send(1'b1, 32'h0f0f_0f0f); req_valid = 1'b0;
    @(posedge clk); #1; rogue = 1'b1;
    idle(TC);
    rogue = 1'b0;
    @(negedge clk);
    chk("float_bus_err", bus_err, err_exp);
    idle(4);
    @(negedge clk);
    chk("float_bus_err_sticky", bus_err, err_exp);
    @(posedge clk); #1;

    // Back-to-back alternating requests with req_valid held.
    b2b = 1'b1;
    for (int i = 0; i < 8; i++) send((i % 2) == 0, $urandom);
    req_valid = 1'b0;
    b2b = 1'b0;
    idle(RW + TC + 2);

    // Random mix with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      send(1'(($urandom_range(0, 1))), $urandom);
      req_valid = 1'b0;
      idle($urandom_range(0, 3));
    end
    idle(RW + TC + 2);

    // Reset in the 2nd RD cycle, with nonzero data already captured.
    send(1'b1, 32'h1234_5678); req_valid = 1'b0;
    send(1'b0, '0);            req_valid = 1'b0;
    idle(RW + TC + 1);
    chk("pre_rst_rdata", rsp_rdata[15:0], 16'h5678);
    send(1'b0, '0);            req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrd_read", read, 1'b1);
    chk("midrd_ad_en", dut.ad_en_q, 1'b0);
    chk("midrd_rsp_valid", rsp_valid, 1'b0);
    chk("midrd_rsp_rdata", rsp_rdata, '0);
    chk("midrd_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrd_req_ready", req_ready, 1'b1);
    idle(RW + 3);

    // Normal operation after the abort.
    send(1'b1, 32'hdead_beef); req_valid = 1'b0;
    send(1'b0, '0);            req_valid = 1'b0;
    idle(RW + TC + 2);
    chk("post_rst_rdata", rsp_rdata[15:0], 16'hbeef);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
